// File: rtl/ama_riscv_mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// ama_riscv_mem_arb_pkg
// Shared types for the memory-side arbiter.
//   arb_mode_t  : grant policy (fixed lowest-index or round-robin)
//   arb_state_t : arbiter request FSM states
// ----------------------------------------------------------------------------
package ama_riscv_mem_arb_pkg;

    typedef enum logic {
        ARB_FIXED,
        ARB_RR
    } arb_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        WR_REQ
    } arb_state_t;

endpackage

// File: rtl/ama_riscv_sync_fifo.sv
// ----------------------------------------------------------------------------
// ama_riscv_sync_fifo
// Single-clock FIFO used to remember the requester id of every read that the
// memory has accepted but not yet answered.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   push, push_data    write side (ignored when full)
//   pop, pop_data      read side; pop_data is the current head (ignored when empty)
//   full, empty, count occupancy status, count is registered
// ----------------------------------------------------------------------------
module ama_riscv_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            // explicit wrap keeps DEPTH=1 legal
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// ----------------------------------------------------------------------------
// ama_riscv_mem_arb
// Merges NR cache read channels and one write-back channel onto a single
// in-order memory port. Reads are tracked by requester id in a FIFO so the
// in-order memory responses can be steered back to whoever issued them.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_r_valid/ready/addr           per-requester read request (addr packed NR*AW)
//   req_w_valid/ready/addr/data      write-back request
//   rsp_valid/ready, rsp_data        per-requester read response, data broadcast
//   mem_req_r_valid/ready/addr       memory read request
//   mem_req_w_valid/ready/addr/data  memory write request
//   mem_rsp_valid/ready/data         in-order memory read response
//   outstanding_cnt                  reads accepted by memory, not yet answered
// ----------------------------------------------------------------------------
module ama_riscv_mem_arb
    import ama_riscv_mem_arb_pkg::*;
#(
    parameter int        NR          = 2,
    parameter int        AW          = 32,
    parameter int        DW          = 128,
    parameter int        OUTSTANDING = 4,
    parameter arb_mode_t MODE        = ARB_RR
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NR-1:0]                 req_r_valid,
    output logic [NR-1:0]                 req_r_ready,
    input  logic [NR*AW-1:0]              req_r_addr,
    input  logic                          req_w_valid,
    output logic                          req_w_ready,
    input  logic [AW-1:0]                 req_w_addr,
    input  logic [DW-1:0]                 req_w_data,
    output logic [NR-1:0]                 rsp_valid,
    input  logic [NR-1:0]                 rsp_ready,
    output logic [DW-1:0]                 rsp_data,
    output logic                          mem_req_r_valid,
    input  logic                          mem_req_r_ready,
    output logic [AW-1:0]                 mem_req_r_addr,
    output logic                          mem_req_w_valid,
    input  logic                          mem_req_w_ready,
    output logic [AW-1:0]                 mem_req_w_addr,
    output logic [DW-1:0]                 mem_req_w_data,
    input  logic                          mem_rsp_valid,
    output logic                          mem_rsp_ready,
    input  logic [DW-1:0]                 mem_rsp_data,
    output logic [$clog2(OUTSTANDING):0]  outstanding_cnt
);

    localparam int IDW = (NR > 1) ? $clog2(NR) : 1;

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;

    logic           win_found;
    logic [IDW-1:0] win_id;
    int             cand;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [IDW-1:0] head_id;

    // Winner search. RR starts one past the last grant and wraps; fixed mode
    // always scans from index 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int k = 0; k < NR; k++) begin
            if (MODE == ARB_RR) cand = (int'(rr_ptr_q) + 1 + k) % NR;
            else                cand = k;
            if (!win_found && req_r_valid[cand]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        addr_d      = addr_q;
        data_d      = data_q;
        req_r_ready = '0;
        req_w_ready = 1'b0;
        fifo_push   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // write-back first so it lands before a refill of the same line
                if (req_w_valid) begin
                    req_w_ready = 1'b1;
                    addr_d      = req_w_addr;
                    data_d      = req_w_data;
                    state_d     = WR_REQ;
                end else if (win_found && !fifo_full) begin
                    req_r_ready[win_id] = 1'b1;
                    addr_d  = req_r_addr[int'(win_id)*AW +: AW];
                    id_d    = win_id;
                    state_d = RD_REQ;
                    if (MODE == ARB_RR) rr_ptr_d = win_id;
                end
            end
            RD_REQ: begin
                if (mem_req_r_ready) begin
                    fifo_push = 1'b1;
                    state_d   = IDLE;
                end
            end
            WR_REQ: begin
                if (mem_req_w_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDW'(NR-1);
            id_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign mem_req_r_valid = (state_q == RD_REQ);
    assign mem_req_w_valid = (state_q == WR_REQ);
    assign mem_req_r_addr  = addr_q;
    assign mem_req_w_addr  = addr_q;
    assign mem_req_w_data  = data_q;

    ama_riscv_sync_fifo #(
        .DW    (IDW),
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (id_q),
        .pop       (fifo_pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_cnt)
    );

    // Responses pass straight through to the requester at the FIFO head.
    always_comb begin
        rsp_valid     = '0;
        mem_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head_id] = mem_rsp_valid;
            mem_rsp_ready      = rsp_ready[head_id];
        end
    end

    assign rsp_data = mem_rsp_data;
    assign fifo_pop = mem_rsp_valid && mem_rsp_ready;

    // Memory must never answer a read the arbiter has not issued.
    assert property (@(posedge clk) disable iff (rst) !(mem_rsp_valid && fifo_empty));

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
module tb_ama_riscv_mem_arb;
    import ama_riscv_mem_arb_pkg::*;

    localparam int NR = 2, AW = 32, DW = 128, OS = 4;
    localparam int CW = $clog2(OS) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_r_valid, req_r_ready, fx_req_r_ready;
    logic [NR*AW-1:0] req_r_addr;
    logic             req_w_valid, req_w_ready, fx_req_w_ready;
    logic [AW-1:0]    req_w_addr;
    logic [DW-1:0]    req_w_data;
    logic [NR-1:0]    rsp_valid, rsp_ready, fx_rsp_valid;
    logic [DW-1:0]    rsp_data, fx_rsp_data;
    logic             mem_req_r_valid, mem_req_r_ready, fx_mem_req_r_valid;
    logic [AW-1:0]    mem_req_r_addr, fx_mem_req_r_addr;
    logic             mem_req_w_valid, mem_req_w_ready, fx_mem_req_w_valid;
    logic [AW-1:0]    mem_req_w_addr, fx_mem_req_w_addr;
    logic [DW-1:0]    mem_req_w_data, fx_mem_req_w_data;
    logic             mem_rsp_valid, mem_rsp_ready, fx_mem_rsp_valid, fx_mem_rsp_ready;
    logic [DW-1:0]    mem_rsp_data;
    logic [CW-1:0]    outstanding_cnt, fx_outstanding_cnt;

    ama_riscv_mem_arb #(.NR(NR), .AW(AW), .DW(DW), .OUTSTANDING(OS), .MODE(ARB_RR)) dut (
        .clk(clk), .rst(rst),
        .req_r_valid(req_r_valid), .req_r_ready(req_r_ready), .req_r_addr(req_r_addr),
        .req_w_valid(req_w_valid), .req_w_ready(req_w_ready),
        .req_w_addr(req_w_addr), .req_w_data(req_w_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_req_r_valid(mem_req_r_valid), .mem_req_r_ready(mem_req_r_ready),
        .mem_req_r_addr(mem_req_r_addr),
        .mem_req_w_valid(mem_req_w_valid), .mem_req_w_ready(mem_req_w_ready),
        .mem_req_w_addr(mem_req_w_addr), .mem_req_w_data(mem_req_w_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .outstanding_cnt(outstanding_cnt)
    );

    // Fixed-priority instance shares requests; it only gets responses when
    // the bench explicitly drives fx_mem_rsp_valid.
    ama_riscv_mem_arb #(.NR(NR), .AW(AW), .DW(DW), .OUTSTANDING(OS), .MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst(rst),
        .req_r_valid(req_r_valid), .req_r_ready(fx_req_r_ready), .req_r_addr(req_r_addr),
        .req_w_valid(req_w_valid), .req_w_ready(fx_req_w_ready),
        .req_w_addr(req_w_addr), .req_w_data(req_w_data),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fx_rsp_data),
        .mem_req_r_valid(fx_mem_req_r_valid), .mem_req_r_ready(mem_req_r_ready),
        .mem_req_r_addr(fx_mem_req_r_addr),
        .mem_req_w_valid(fx_mem_req_w_valid), .mem_req_w_ready(mem_req_w_ready),
        .mem_req_w_addr(fx_mem_req_w_addr), .mem_req_w_data(fx_mem_req_w_data),
        .mem_rsp_valid(fx_mem_rsp_valid), .mem_rsp_ready(fx_mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .outstanding_cnt(fx_outstanding_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
    } ent_t;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
        return {4{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        req_r_valid      = '0;
        req_r_addr       = '0;
        req_w_valid      = 1'b0;
        req_w_addr       = '0;
        req_w_data       = '0;
        rsp_ready        = '0;
        mem_req_r_ready  = 1'b0;
        mem_req_w_ready  = 1'b0;
        mem_rsp_valid    = 1'b0;
        mem_rsp_data     = '0;
        fx_mem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Single isolated read through to the memory handshake (mem ready high).
    task automatic issue(input int id, input logic [AW-1:0] a);
        req_r_valid = '0;
        req_r_valid[id] = 1'b1;
        req_r_addr[id*AW +: AW] = a;
        mem_req_r_ready = 1'b1;
        settle();
        chk("io_grant", DW'(req_r_ready), DW'(1 << id));
        cyc();
        req_r_valid = '0;
        cyc();
    endtask

    // reference model state for the random phase
    ent_t          q[$];
    logic          m_busy, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_id, last, win, ng;
    logic          e_wr, e_mrr;
    logic [NR-1:0] e_rr, e_rsp;
    int            rr_seq[$], fx_seq[$];

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        settle();
        chk("rst_r_ready", DW'(req_r_ready), '0);
        chk("rst_w_ready", DW'(req_w_ready), '0);
        chk("rst_mem_r_valid", DW'(mem_req_r_valid), '0);
        chk("rst_mem_w_valid", DW'(mem_req_w_valid), '0);
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_mem_rsp_ready", DW'(mem_rsp_ready), '0);
        chk("rst_cnt", DW'(outstanding_cnt), '0);
        chk("rst_mem_r_addr", DW'(mem_req_r_addr), '0);
        chk("rst_mem_w_data", mem_req_w_data, '0);

        // ---------------- single read ----------------
        req_r_valid = 2'b10;
        req_r_addr[AW +: AW] = 32'h40;
        settle();
        chk("sr_grant", DW'(req_r_ready), DW'(2'b10));
        chk("sr_mem_idle", DW'(mem_req_r_valid), '0);
        cyc();
        req_r_valid = '0;
        mem_req_r_ready = 1'b1;
        settle();
        chk("sr_mem_valid", DW'(mem_req_r_valid), DW'(1'b1));
        chk("sr_mem_addr", DW'(mem_req_r_addr), DW'(32'h40));
        cyc();
        mem_req_r_ready = 1'b0;
        settle();
        chk("sr_mem_done", DW'(mem_req_r_valid), '0);
        chk("sr_cnt1", DW'(outstanding_cnt), DW'(1));
        cyc();
        cyc();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {16{8'hAA}};
        rsp_ready     = 2'b11;
        settle();
        chk("sr_rsp_valid", DW'(rsp_valid), DW'(2'b10));
        chk("sr_rsp_data", rsp_data, {16{8'hAA}});
        chk("sr_mem_rsp_ready", DW'(mem_rsp_ready), DW'(1'b1));
        cyc();
        mem_rsp_valid = 1'b0;
        settle();
        chk("sr_cnt0", DW'(outstanding_cnt), '0);
        chk("sr_rsp_gone", DW'(rsp_valid), '0);

        // ---------------- contention: RR vs fixed ----------------
        do_reset();
        req_r_addr      = {32'h200, 32'h100};
        req_r_valid     = 2'b11;
        mem_req_r_ready = 1'b1;
        rsp_ready       = 2'b11;
        for (int c = 0; c < 12; c++) begin
            mem_rsp_valid    = (outstanding_cnt != '0);
            fx_mem_rsp_valid = (fx_outstanding_cnt != '0);
            settle();
            if (req_r_ready != '0)    rr_seq.push_back(int'(req_r_ready));
            if (fx_req_r_ready != '0) fx_seq.push_back(int'(fx_req_r_ready));
            cyc();
        end
        chk("rr_ngrants", DW'(rr_seq.size()), DW'(6));
        chk("fx_ngrants", DW'(fx_seq.size()), DW'(6));
        for (int k = 0; k < 6 && k < rr_seq.size(); k++)
            chk($sformatf("rr_order%0d", k), DW'(rr_seq[k]), DW'((k % 2 == 0) ? 1 : 2));
        for (int k = 0; k < 6 && k < fx_seq.size(); k++)
            chk($sformatf("fx_order%0d", k), DW'(fx_seq[k]), DW'(1));

        // ---------------- write priority ----------------
        do_reset();
        req_w_valid = 1'b1;
        req_w_addr  = 32'h80;
        req_w_data  = {16{8'h55}};
        req_r_valid = 2'b01;
        req_r_addr[0 +: AW] = 32'h300;
        settle();
        chk("wp_w_ready", DW'(req_w_ready), DW'(1'b1));
        chk("wp_r_blocked", DW'(req_r_ready), '0);
        cyc();
        req_w_valid = 1'b0;
        mem_req_w_ready = 1'b1;
        settle();
        chk("wp_mem_w_valid", DW'(mem_req_w_valid), DW'(1'b1));
        chk("wp_mem_w_addr", DW'(mem_req_w_addr), DW'(32'h80));
        chk("wp_mem_w_data", mem_req_w_data, {16{8'h55}});
        chk("wp_r_busy", DW'(req_r_ready), '0);
        cyc();
        mem_req_w_ready = 1'b0;
        mem_req_r_ready = 1'b1;
        settle();
        chk("wp_w_done", DW'(mem_req_w_valid), '0);
        chk("wp_r_grant", DW'(req_r_ready), DW'(2'b01));
        chk("wp_no_track", DW'(outstanding_cnt), '0);
        cyc();
        req_r_valid = '0;
        settle();
        chk("wp_mem_r_addr", DW'(mem_req_r_addr), DW'(32'h300));
        cyc();
        settle();
        chk("wp_cnt1", DW'(outstanding_cnt), DW'(1));

        // ---------------- outstanding limit ----------------
        do_reset();
        req_r_valid = 2'b01;
        req_r_addr[0 +: AW] = 32'h400;
        mem_req_r_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 14; c++) begin
            settle();
            if (req_r_ready[0]) ng++;
            cyc();
        end
        chk("ol_accepted", DW'(ng), DW'(4));
        settle();
        chk("ol_blocked", DW'(req_r_ready), '0);
        chk("ol_cnt4", DW'(outstanding_cnt), DW'(4));
        mem_rsp_valid = 1'b1;
        rsp_ready     = 2'b01;
        settle();
        chk("ol_pop_ready", DW'(mem_rsp_ready), DW'(1'b1));
        chk("ol_still_blocked", DW'(req_r_ready), '0);
        cyc();
        mem_rsp_valid = 1'b0;
        settle();
        chk("ol_cnt3", DW'(outstanding_cnt), DW'(3));
        chk("ol_fifth", DW'(req_r_ready), DW'(2'b01));

        // ---------------- in-order routing with backpressure ----------------
        do_reset();
        issue(1, 32'h1000);
        issue(0, 32'h2000);
        issue(1, 32'h3000);
        settle();
        chk("io_cnt3", DW'(outstanding_cnt), DW'(3));
        mem_rsp_valid = 1'b1;
        rsp_ready     = 2'b10;
        settle();
        chk("io_rsp1", DW'(rsp_valid), DW'(2'b10));
        chk("io_rdy1", DW'(mem_rsp_ready), DW'(1'b1));
        cyc();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("io_hold_valid", DW'(rsp_valid), DW'(2'b01));
            chk("io_hold_ready", DW'(mem_rsp_ready), '0);
            cyc();
        end
        rsp_ready = 2'b11;
        settle();
        chk("io_rsp0", DW'(rsp_valid), DW'(2'b01));
        chk("io_rdy0", DW'(mem_rsp_ready), DW'(1'b1));
        cyc();
        settle();
        chk("io_rsp1b", DW'(rsp_valid), DW'(2'b10));
        chk("io_rdy1b", DW'(mem_rsp_ready), DW'(1'b1));
        cyc();
        mem_rsp_valid = 1'b0;
        settle();
        chk("io_cnt0", DW'(outstanding_cnt), '0);

        // ---------------- reset mid RD_REQ ----------------
        do_reset();
        req_r_valid = 2'b01;
        settle();
        chk("mr_grant0", DW'(req_r_ready), DW'(2'b01));
        cyc();
        req_r_valid = '0;
        settle();
        chk("mr_in_rd", DW'(mem_req_r_valid), DW'(1'b1));
        do_reset();
        settle();
        chk("mr_r_valid", DW'(mem_req_r_valid), '0);
        chk("mr_w_valid", DW'(mem_req_w_valid), '0);
        chk("mr_rsp_valid", DW'(rsp_valid), '0);
        chk("mr_cnt", DW'(outstanding_cnt), '0);
        req_r_valid = 2'b11;
        settle();
        chk("mr_ptr_restored", DW'(req_r_ready), DW'(2'b01));

        // ---------------- randomized vs reference model ----------------
        do_reset();
        q.delete();
        m_busy = 1'b0;
        m_wr   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_id   = 0;
        last   = NR - 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_r_valid[i] && $urandom_range(2) == 0) begin
                    req_r_valid[i] = 1'b1;
                    req_r_addr[i*AW +: AW] = $urandom & 32'hFFFF_FFC0;
                end
            end
            if (!req_w_valid && $urandom_range(5) == 0) begin
                req_w_valid = 1'b1;
                req_w_addr  = $urandom & 32'hFFFF_FFC0;
                req_w_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_req_r_ready = 1'($urandom_range(1));
            mem_req_w_ready = 1'($urandom_range(1));
            rsp_ready       = 2'($urandom_range(3));
            mem_rsp_valid   = (q.size() != 0) && ($urandom_range(1) == 1);
            mem_rsp_data    = (q.size() != 0) ? rdata(q[0].addr) : '0;
            settle();

            e_wr = !m_busy && req_w_valid;
            e_rr = '0;
            win  = -1;
            if (!m_busy && !req_w_valid && q.size() < OS)
                for (int k = 1; k <= NR; k++)
                    if (win < 0 && req_r_valid[(last + k) % NR]) win = (last + k) % NR;
            if (win >= 0) e_rr[win] = 1'b1;
            e_rsp = '0;
            e_mrr = 1'b0;
            if (q.size() != 0) begin
                e_rsp[q[0].id] = mem_rsp_valid;
                e_mrr = rsp_ready[q[0].id];
            end

            chk("rnd_w_ready", DW'(req_w_ready), DW'(e_wr));
            chk("rnd_r_ready", DW'(req_r_ready), DW'(e_rr));
            chk("rnd_mem_r_valid", DW'(mem_req_r_valid), DW'(m_busy && !m_wr));
            chk("rnd_mem_w_valid", DW'(mem_req_w_valid), DW'(m_busy && m_wr));
            if (m_busy && !m_wr) chk("rnd_mem_r_addr", DW'(mem_req_r_addr), DW'(m_addr));
            if (m_busy && m_wr) begin
                chk("rnd_mem_w_addr", DW'(mem_req_w_addr), DW'(m_addr));
                chk("rnd_mem_w_data", mem_req_w_data, m_data);
            end
            chk("rnd_cnt", DW'(outstanding_cnt), DW'(q.size()));
            chk("rnd_rsp_valid", DW'(rsp_valid), DW'(e_rsp));
            chk("rnd_mem_rsp_ready", DW'(mem_rsp_ready), DW'(e_mrr));
            if (e_rsp != '0) chk("rnd_rsp_data", rsp_data, rdata(q[0].addr));

            cyc();
            if (mem_rsp_valid && e_mrr) void'(q.pop_front());
            if (m_busy) begin
                if (!m_wr && mem_req_r_ready) begin
                    q.push_back('{m_id, m_addr});
                    m_busy = 1'b0;
                end else if (m_wr && mem_req_w_ready) begin
                    m_busy = 1'b0;
                end
            end else if (e_wr) begin
                m_busy = 1'b1;
                m_wr   = 1'b1;
                m_addr = req_w_addr;
                m_data = req_w_data;
                req_w_valid = 1'b0;
            end else if (win >= 0) begin
                m_busy = 1'b1;
                m_wr   = 1'b0;
                m_id   = win;
                m_addr = req_r_addr[win*AW +: AW];
                last   = win;
                req_r_valid[win] = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
